// File: rtl/alu_74382_serial_if.sv
// Request/response bundle for the chunk-serial 74382 ALU.
// Master drives requests and out_ready; slave returns in_ready and the registered result.
interface alu_74382_serial_if #(
  parameter int WORD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        sel;
  logic              carry_in;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] result;
  logic              carry_out;
  logic              overflow;

  modport master (
    output in_valid, sel, carry_in, port_a, port_b, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, sel, carry_in, port_a, port_b, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/alu_74382_serial.sv
// 74382 ALU evaluated CHUNK_W bits per cycle, LSB first; result valid WORD_W/CHUNK_W edges after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module alu_74382_serial #(
  parameter int WORD_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_74382_serial_if.slave  bus
);
  localparam int N     = WORD_W / CHUNK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [2:0]        sel;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
  } op_t;

  state_t            state;
  state_t            state_nxt;
  op_t               op_q;
  logic [IDX_W-1:0]  idx;
  logic              cy_q;
  logic [WORD_W-1:0] result_q;
  logic              carry_out_q;
  logic              overflow_q;

  logic              accept;
  logic              in_ready_i;
  logic              out_valid_i;
  logic              chunk_last;

  int                base;
  logic [CHUNK_W-1:0] a_c;
  logic [CHUNK_W-1:0] b_c;
  logic [CHUNK_W-1:0] x_c;
  logic [CHUNK_W-1:0] y_c;
  logic [CHUNK_W:0]   sum_c;
  logic [CHUNK_W-1:0] chunk_res;
  logic               is_arith;
  logic               chunk_cout;
  logic               chunk_ovf;

  // One chunk of the 74382: subtraction is an add of the inverted operand.
  always_comb begin
    base      = int'(idx) * CHUNK_W;
    a_c       = op_q.a[base +: CHUNK_W];
    b_c       = op_q.b[base +: CHUNK_W];
    x_c       = a_c;
    y_c       = b_c;
    is_arith  = 1'b0;
    case (op_q.sel)
      3'b001: begin
        x_c      = ~a_c;
        is_arith = 1'b1;
      end
      3'b010: begin
        y_c      = ~b_c;
        is_arith = 1'b1;
      end
      3'b011:  is_arith = 1'b1;
      default: is_arith = 1'b0;
    endcase

    sum_c = {1'b0, x_c} + {1'b0, y_c} + {{CHUNK_W{1'b0}}, cy_q};

    case (op_q.sel)
      3'b000:  chunk_res = '0;
      3'b100:  chunk_res = a_c ^ b_c;
      3'b101:  chunk_res = a_c | b_c;
      3'b110:  chunk_res = a_c & b_c;
      3'b111:  chunk_res = '1;
      default: chunk_res = sum_c[CHUNK_W-1:0];
    endcase

    // Carry into the chunk MSB is recovered from the sum bit and its operand bits.
    chunk_cout = is_arith & sum_c[CHUNK_W];
    chunk_ovf  = is_arith & (sum_c[CHUNK_W] ^
                 (sum_c[CHUNK_W-1] ^ x_c[CHUNK_W-1] ^ y_c[CHUNK_W-1]));
  end

  assign chunk_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_i  = 1'b0;
    out_valid_i = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_i = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (chunk_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_i = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      idx         <= '0;
      cy_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      op_q.sel <= bus.sel;
      op_q.a   <= bus.port_a;
      op_q.b   <= bus.port_b;
      cy_q     <= bus.carry_in;
      idx      <= '0;
    end else if (state == BUSY) begin
      result_q[base +: CHUNK_W] <= chunk_res;
      cy_q                      <= sum_c[CHUNK_W];
      if (chunk_last) begin
        // Park idx at 0 so the chunk select stays in range outside BUSY.
        idx         <= '0;
        carry_out_q <= chunk_cout;
        overflow_q  <= chunk_ovf;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_i;
  assign bus.out_valid = out_valid_i;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule
